// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, controller states and the
// alignment rule used when MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_WAIT  = 2'd1,
    ST_MERGE = 2'd2
  } lsu_state_e;

  // Size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: little-endian load extract/extend and sub-word store merge.
// Half accesses use only off[1]; word accesses ignore the offset.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_new,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_word[7:0];
    w_half   = i_off[1] ? i_word[31:16] : i_word[15:0];
    o_load   = i_word;
    o_merged = i_new;
    unique case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    case (i_size)
      SZ_BYTE: begin
        o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        unique case (i_off)
          2'd0:    o_merged = {i_word[31:8], i_new[7:0]};
          2'd1:    o_merged = {i_word[31:16], i_new[7:0], i_word[7:0]};
          2'd2:    o_merged = {i_word[31:24], i_new[7:0], i_word[15:0]};
          default: o_merged = {i_new[7:0], i_word[23:0]};
        endcase
      end
      SZ_HALF: begin
        o_load   = {{16{~i_unsigned & w_half[15]}}, w_half};
        o_merged = i_off[1] ? {i_new[15:0], i_word[15:0]} : {i_word[31:16], i_new[15:0]};
      end
      default: begin
        o_load   = i_word;
        o_merged = i_new;
      end
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// MEM-stage requester for a one-cycle synchronous-read data memory; sub-word stores are
// read-modify-write. Define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_ask_addr,
  output logic [31:0]       o_dmem_wdata,
  input  logic [31:0]       i_dmem_rdata
);

  localparam int unsigned IdxHi = DEPTH_LOG2 + 1;

  lsu_state_e        r_state, w_state_nxt;
  logic [1:0]        r_off, r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_resp_pend, r_resp_err;

  logic              w_accept, w_misalign, w_latch, w_pend_nxt, w_err_nxt;
  logic              w_valid, w_err, w_we;
  logic [ADDR_W-1:0] w_req_aligned, w_addr;
  logic [31:0]       w_wdata, w_rdata, w_load, w_merged;

  // Upper bits pass through untouched; aliasing above the index is the memory's business.
  assign w_req_aligned = {i_req_addr[ADDR_W-1:IdxHi+1], i_req_addr[IdxHi:2], 2'b00};
  assign o_req_ready   = (r_state == IDLE);
  assign w_accept      = i_req_valid & o_req_ready;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(i_req_size, i_req_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .i_word     (i_dmem_rdata),
    .i_new      (r_wdata),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_pend_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_we        = 1'b0;
    w_addr      = w_req_aligned;
    w_wdata     = i_req_wdata;
    w_valid     = r_resp_pend;
    w_rdata     = 32'h0;
    w_err       = r_resp_err;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_misalign) begin
            w_pend_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end else if (!i_req_we) begin
            w_latch     = 1'b1;
            w_state_nxt = LD_WAIT;
          end else if (i_req_size == SZ_BYTE || i_req_size == SZ_HALF) begin
            w_latch     = 1'b1;
            w_state_nxt = ST_MERGE;
          end else begin
            w_we       = 1'b1;
            w_pend_nxt = 1'b1;
          end
        end
      end
      LD_WAIT: begin
        w_addr      = r_addr;
        w_valid     = 1'b1;
        w_rdata     = w_load;
        w_err       = 1'b0;
        w_state_nxt = IDLE;
      end
      ST_MERGE: begin
        w_addr      = r_addr;
        w_we        = 1'b1;
        w_wdata     = w_merged;
        w_valid     = 1'b1;
        w_err       = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset gates every externally visible effect, including an in-flight merge write.
  assign o_resp_valid    = w_valid & ~i_rst;
  assign o_resp_rdata    = o_resp_valid ? w_rdata : 32'h0;
  assign o_resp_err      = w_err & o_resp_valid;
  assign o_dmem_we       = w_we & ~i_rst;
  assign o_dmem_ask_addr = w_addr;
  assign o_dmem_wdata    = w_wdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_resp_pend <= 1'b0;
      r_resp_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_resp_pend <= w_pend_nxt;
      r_resp_err  <= w_err_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_latch) begin
      r_off      <= i_req_addr[1:0];
      r_size     <= i_req_size;
      r_unsigned <= i_req_unsigned;
      r_addr     <= w_req_aligned;
      r_wdata    <= i_req_wdata;
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboard bench for lsu_dmem_ctrl: a byte-lane reference model fills response and
// write queues; a negedge monitor pops and compares them. Honours MISALIGN_TRAP_EN.
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, dmem_we;
  logic [31:0] resp_rdata, dmem_ask_addr, dmem_wdata, dmem_rdata;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.ADDR_W(32), .DEPTH_LOG2(8)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_we        (req_we),
    .i_req_size      (req_size),
    .i_req_unsigned  (req_unsigned),
    .i_req_addr      (req_addr),
    .i_req_wdata     (req_wdata),
    .o_resp_valid    (resp_valid),
    .o_resp_rdata    (resp_rdata),
    .o_resp_err      (resp_err),
    .o_dmem_we       (dmem_we),
    .o_dmem_ask_addr (dmem_ask_addr),
    .o_dmem_wdata    (dmem_wdata),
    .i_dmem_rdata    (dmem_rdata)
  );

  // Synchronous-read memory the DUT talks to, plus the model's own copy.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  always @(posedge clk) begin
    if (dmem_we) mem[dmem_ask_addr[9:2]] <= dmem_wdata;
    dmem_rdata <= mem[dmem_ask_addr[9:2]];
  end

  typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
  typedef struct packed {logic [7:0] idx; logic [31:0] data;} wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];
  exp_t mon_e;
  wr_t  mon_w;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (dmem_we) begin
      check("dmem_align", {30'b0, dmem_ask_addr[1:0]}, 32'h0);
      if (wr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL dmem_we_unexpected: got write %h at idx %0d want none", dmem_wdata,
                 dmem_ask_addr[9:2]);
      end else begin
        mon_w = wr_q.pop_front();
        check("dmem_wdata", dmem_wdata, mon_w.data);
        check("dmem_widx", {24'b0, dmem_ask_addr[9:2]}, {24'b0, mon_w.idx});
      end
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected: got resp %h want none", resp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, mon_e.rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
      end
    end
  end

  // Reference model: byte-lane arithmetic on the model memory.
  function automatic void model(input bit we, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output bit trap);
    int          nbytes, off, idx;
    logic [31:0] mask, val;
    exp_t        e;
    wr_t         w;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    idx    = int'(addr[9:2]);
    off    = (int'(addr[1:0]) / nbytes) * nbytes;
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
`ifdef MISALIGN_TRAP_EN
    trap = (int'(addr[1:0]) % nbytes) != 0;
`else
    trap = 1'b0;
`endif
    e.err   = trap;
    e.rdata = 32'h0;
    if (!trap) begin
      if (!we) begin
        val = (ref_mem[idx] >> (8 * off)) & mask;
        if (!uns && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
        e.rdata = val;
      end else begin
        ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        w.idx  = idx[7:0];
        w.data = ref_mem[idx];
        wr_q.push_back(w);
      end
    end
    exp_q.push_back(e);
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after the response.
  task automatic do_op(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    bit trap;
    bit exp_ready;
    int cyc;
    model(we, size, uns, addr, wd, trap);
    exp_ready    = trap || (we && size[1]);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    cyc = 0;
    @(negedge clk);
    while (!req_ready && cyc < 4) begin
      @(posedge clk); #1;
      @(negedge clk);
      cyc++;
    end
    check("req_ready_issue", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    check("resp_latency", cyc, 32'd1);
    check("ready_at_resp", {31'b0, req_ready}, {31'b0, exp_ready});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    bit          dummy_trap;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_dmem_we", {31'b0, dmem_we}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;

    do_op(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF);   // sw
    do_op(0, 2'd2, 0, 32'h10, 32'h0);           // lw
    do_op(0, 2'd0, 0, 32'h11, 32'h0);           // lb
    do_op(0, 2'd0, 1, 32'h11, 32'h0);           // lbu
    do_op(0, 2'd1, 0, 32'h12, 32'h0);           // lh
    do_op(1, 2'd0, 0, 32'h13, 32'h0000_0055);   // sb
    do_op(1, 2'd1, 0, 32'h10, 32'hFFFF_1234);   // sh then immediate lw
    do_op(0, 2'd2, 0, 32'h10, 32'h0);

    // Reset during ST_MERGE: no write, no response, ready again after.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_00AA;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_dmem_we", {31'b0, dmem_we}, 32'h0);
    check("rstmid_resp_valid", {31'b0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_req_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    do_op(0, 2'd2, 0, 32'h10, 32'h0);

    do_op(0, 2'd2, 0, 32'h12, 32'h0);           // misaligned word
    do_op(0, 2'd1, 1, 32'h13, 32'h0);           // misaligned half
    do_op(1, 2'd1, 0, 32'h21, 32'h0000_CAFE);
    do_op(1, 2'd3, 0, 32'h26, 32'h1357_9BDF);   // size 11 acts as word
    do_op(0, 2'd3, 0, 32'h24, 32'h0);
    do_op(0, 2'd0, 0, 32'hFFFF_FC13, 32'h0);    // upper bits alias

    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      a[9:6] = 4'b0;
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom);
    end

    repeat (3) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("wr_q_drained", wr_q.size(), 32'd0);
    for (int i = 0; i < 256; i++) check("mem_final", mem[i], ref_mem[i]);
    dummy_trap = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
